// File: rtl/instr_encoder_loader.sv
// Program loader: turns symbolic WISC instruction fields into 16-bit words
// and writes them sequentially into instruction memory until HLT, error or overflow.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs,
  input  logic [3:0]        in_rt,
  input  logic [8:0]        in_imm,
  input  logic [2:0]        in_cond,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0]        ERR_FIELD = 2'b01;
  localparam logic [1:0]        ERR_OVFL  = 2'b10;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        errc_q, errc_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [15:0]       enc_word;
  logic              enc_legal;

  // Field packing per opcode; anything not part of the format stays zero.
  always_comb begin
    enc_word  = 16'h0000;
    enc_legal = 1'b1;
    case (in_opcode)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: enc_word = {in_opcode, in_rd, in_rs, in_rt};
      4'h4, 4'h5, 4'h6: begin
        enc_word  = {in_opcode, in_rd, in_rs, in_imm[3:0]};
        enc_legal = (in_imm[8:4] == 5'd0);
      end
      4'h8, 4'h9: begin
        enc_word  = {in_opcode, in_rd, in_rs, in_imm[3:0]};
        enc_legal = (in_imm[8:3] == 6'h00) || (in_imm[8:3] == 6'h3F);
      end
      4'hA, 4'hB: begin
        enc_word  = {in_opcode, in_rd, in_imm[7:0]};
        enc_legal = ~in_imm[8];
      end
      4'hC:    enc_word = {in_opcode, in_cond, in_imm};
      4'hD:    enc_word = {in_opcode, in_cond, 1'b0, in_rs, 4'h0};
      4'hE:    enc_word = {in_opcode, in_rd, 8'h00};
      default: enc_word = 16'hF000;
    endcase
  end

  // Next-state and datapath updates; the write strobe only ever follows an accept.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    errc_d  = errc_q;
    count_d = count_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          if (!enc_legal) begin
            state_d = S_ERR;
            errc_d  = ERR_FIELD;
          end else begin
            we_d    = 1'b1;
            wdata_d = enc_word;
            waddr_d = addr_q;
            if (count_q != COUNT_MAX) count_d = count_q + (ADDR_W+1)'(1);
            if (in_opcode == 4'hF) begin
              state_d = S_DONE;
            end else if (addr_q == LAST_ADDR) begin
              state_d = S_ERR;
              errc_d  = ERR_OVFL;
            end
            if (addr_q != LAST_ADDR) addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = BASE;
          waddr_d = BASE;
          errc_d  = 2'b00;
          count_d = '0;
        end
      end
    endcase
  end

  // Async reset squashes a pending write straight away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= BASE;
      waddr_q <= BASE;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      errc_q  <= 2'b00;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      errc_q  <= errc_d;
      count_q <= count_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign err_code   = errc_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a wide instance for encoding/error cases and a
// 4-word instance for overflow; expected writes are queued and matched cycle by cycle.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN;
  logic       startA, startB;
  logic       inValid;
  logic [3:0] inOpcode, inRd, inRs, inRt;
  logic [8:0] inImm;
  logic [2:0] inCond;

  logic       readyA, weA, busyA, doneA, errA;
  logic [7:0] addrA;
  logic [15:0] wdataA;
  logic [1:0] errcA;
  logic [8:0] countA;

  logic       readyB, weB, busyB, doneB, errB;
  logic [1:0] addrB;
  logic [15:0] wdataB;
  logic [1:0] errcB;
  logic [2:0] countB;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dutA (
    .clk(clk), .rst_n(rstN), .start(startA), .in_valid(inValid), .in_ready(readyA),
    .in_opcode(inOpcode), .in_rd(inRd), .in_rs(inRs), .in_rt(inRt), .in_imm(inImm),
    .in_cond(inCond), .imem_we(weA), .imem_addr(addrA), .imem_wdata(wdataA),
    .busy(busyA), .done(doneA), .err(errA), .err_code(errcA), .count(countA)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dutB (
    .clk(clk), .rst_n(rstN), .start(startB), .in_valid(inValid), .in_ready(readyB),
    .in_opcode(inOpcode), .in_rd(inRd), .in_rs(inRs), .in_rt(inRt), .in_imm(inImm),
    .in_cond(inCond), .imem_we(weB), .imem_addr(addrB), .imem_wdata(wdataB),
    .busy(busyB), .done(doneB), .err(errB), .err_code(errcB), .count(countB)
  );

  typedef struct {
    int          sel;
    int          addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t expQ[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  expAddr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Write monitor for the wide instance: every cycle the strobe must match the scoreboard.
  always @(negedge clk) begin : monA
    bit  expWe;
    wr_t head;
    expWe = (expQ.size() > 0) && (expQ[0].sel == 0) && (expQ[0].cyc == cyc);
    checkOutput("we_a", 32'(weA), 32'(expWe));
    if (expWe) begin
      head = expQ.pop_front();
      checkOutput("addr_a", 32'(addrA), 32'(head.addr));
      checkOutput("wdata_a", 32'(wdataA), 32'(head.data));
    end
  end

  // Write monitor for the small instance.
  always @(negedge clk) begin : monB
    bit  expWe;
    wr_t head;
    expWe = (expQ.size() > 0) && (expQ[0].sel == 1) && (expQ[0].cyc == cyc);
    checkOutput("we_b", 32'(weB), 32'(expWe));
    if (expWe) begin
      head = expQ.pop_front();
      checkOutput("addr_b", 32'(addrB), 32'(head.addr));
      checkOutput("wdata_b", 32'(wdataB), 32'(head.data));
    end
  end

  // Drives one bundle for one cycle; a legal accept is expected to write next cycle.
  task automatic applyStimulus(input int sel, input logic [3:0] op, input logic [3:0] rd,
                               input logic [3:0] rs, input logic [3:0] rt,
                               input logic [8:0] imm, input logic [2:0] cond,
                               input bit expWrite, input logic [15:0] word);
    wr_t e;
    inOpcode = op; inRd = rd; inRs = rs; inRt = rt; inImm = imm; inCond = cond;
    inValid  = 1'b1;
    if (expWrite) begin
      e.sel = sel; e.addr = expAddr; e.data = word; e.cyc = cyc + 1;
      expQ.push_back(e);
      expAddr++;
    end
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic pulseStart(input int sel);
    if (sel == 0) startA = 1'b1; else startB = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0; startB = 1'b0;
    expAddr = 0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstN = 1'b0; startA = 1'b0; startB = 1'b0; inValid = 1'b0;
    inOpcode = 4'h0; inRd = 4'h0; inRs = 4'h0; inRt = 4'h0; inImm = 9'h0; inCond = 3'h0;
    #1;
    checkOutput("rst_ready", 32'(readyA), 0);
    checkOutput("rst_we", 32'(weA), 0);
    checkOutput("rst_addr", 32'(addrA), 0);
    checkOutput("rst_wdata", 32'(wdataA), 0);
    checkOutput("rst_busy", 32'(busyA), 0);
    checkOutput("rst_done", 32'(doneA), 0);
    checkOutput("rst_err", 32'(errA), 0);
    checkOutput("rst_errc", 32'(errcA), 0);
    checkOutput("rst_count", 32'(countA), 0);
    idleCycles(2);
    rstN = 1'b1;
    idleCycles(1);

    // ADD then HLT
    pulseStart(0);
    checkOutput("load_busy", 32'(busyA), 1);
    checkOutput("load_ready", 32'(readyA), 1);
    applyStimulus(0, 4'h0, 4'h3, 4'h1, 4'h2, 9'h000, 3'h0, 1, 16'h0312);
    applyStimulus(0, 4'hF, 4'h5, 4'h6, 4'h7, 9'h1AA, 3'h5, 1, 16'hF000);
    checkOutput("hlt_done", 32'(doneA), 1);
    checkOutput("hlt_count", 32'(countA), 2);
    checkOutput("hlt_ready", 32'(readyA), 0);
    checkOutput("hlt_busy", 32'(busyA), 0);
    idleCycles(2);
    checkOutput("done_sticky", 32'(doneA), 1);

    // Back-to-back mixed formats with junk in unused fields
    pulseStart(0);
    checkOutput("restart_count", 32'(countA), 0);
    checkOutput("restart_done", 32'(doneA), 0);
    applyStimulus(0, 4'h8, 4'h4, 4'h5, 4'hF, 9'h1FE, 3'h6, 1, 16'h845E);
    applyStimulus(0, 4'hA, 4'h2, 4'h7, 4'h3, 9'h0AB, 3'h1, 1, 16'hA2AB);
    applyStimulus(0, 4'hC, 4'hA, 4'hB, 4'h1, 9'h1FF, 3'h3, 1, 16'hC7FF);
    applyStimulus(0, 4'hD, 4'hC, 4'h6, 4'h5, 9'h1FF, 3'h7, 1, 16'hDE60);
    applyStimulus(0, 4'hE, 4'h9, 4'h3, 4'h4, 9'h055, 3'h2, 1, 16'hE900);
    applyStimulus(0, 4'hF, 4'h0, 4'h0, 4'h0, 9'h000, 3'h0, 1, 16'hF000);
    checkOutput("b2b_count", 32'(countA), 6);
    checkOutput("b2b_done", 32'(doneA), 1);

    // Illegal shift immediate after one ADD
    pulseStart(0);
    applyStimulus(0, 4'h0, 4'h1, 4'h2, 4'h3, 9'h000, 3'h0, 1, 16'h0123);
    applyStimulus(0, 4'h4, 4'h1, 4'h2, 4'h3, 9'h010, 3'h0, 0, 16'h0000);
    checkOutput("sll_err", 32'(errA), 1);
    checkOutput("sll_errc", 32'(errcA), 1);
    checkOutput("sll_ready", 32'(readyA), 0);
    checkOutput("sll_count", 32'(countA), 1);
    idleCycles(2);
    pulseStart(0);
    checkOutput("clr_err", 32'(errA), 0);
    checkOutput("clr_errc", 32'(errcA), 0);
    checkOutput("clr_count", 32'(countA), 0);
    applyStimulus(0, 4'h0, 4'h1, 4'h2, 4'h3, 9'h000, 3'h0, 1, 16'h0123);
    applyStimulus(0, 4'h9, 4'h1, 4'h2, 4'h3, 9'h00F, 3'h0, 0, 16'h0000);
    checkOutput("lw_errc", 32'(errcA), 1);
    pulseStart(0);
    applyStimulus(0, 4'h5, 4'h1, 4'h2, 4'h9, 9'h00F, 3'h0, 1, 16'h512F);
    applyStimulus(0, 4'hB, 4'h1, 4'h2, 4'h3, 9'h100, 3'h0, 0, 16'h0000);
    checkOutput("llb_errc", 32'(errcA), 1);
    checkOutput("llb_count", 32'(countA), 1);

    // Overflow on the 4-word instance
    pulseStart(1);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 4'h2, 4'(i), 4'h1, 4'h2, 9'h000, 3'h0, 1, {4'h2, 4'(i), 8'h12});
    checkOutput("ovf_err", 32'(errB), 1);
    checkOutput("ovf_errc", 32'(errcB), 2);
    checkOutput("ovf_count", 32'(countB), 4);
    applyStimulus(1, 4'h0, 4'h7, 4'h7, 4'h7, 9'h000, 3'h0, 0, 16'h0000);
    checkOutput("ovf_ready", 32'(readyB), 0);
    checkOutput("ovf_count2", 32'(countB), 4);

    // HLT landing on the last address finishes cleanly
    pulseStart(1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 4'h1, 4'h1, 4'(i), 4'h3, 9'h000, 3'h0, 1, {8'h11, 4'(i), 4'h3});
    applyStimulus(1, 4'hF, 4'h0, 4'h0, 4'h0, 9'h000, 3'h0, 1, 16'hF000);
    checkOutput("lasthlt_done", 32'(doneB), 1);
    checkOutput("lasthlt_err", 32'(errB), 0);
    checkOutput("lasthlt_count", 32'(countB), 4);

    // Gapped valid with a start pulse mid-LOAD
    pulseStart(0);
    applyStimulus(0, 4'h0, 4'h4, 4'h5, 4'h6, 9'h000, 3'h0, 1, 16'h0456);
    startA = 1'b1;
    idleCycles(1);
    startA = 1'b0;
    applyStimulus(0, 4'h2, 4'h7, 4'h8, 4'h9, 9'h000, 3'h0, 1, 16'h2789);
    idleCycles(2);
    applyStimulus(0, 4'h1, 4'hA, 4'hB, 4'hC, 9'h000, 3'h0, 1, 16'h1ABC);
    checkOutput("gap_count", 32'(countA), 3);
    checkOutput("gap_busy", 32'(busyA), 1);

    // Reset lands while a write is pending
    inOpcode = 4'h3; inRd = 4'h1; inRs = 4'h1; inRt = 4'h1; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    checkOutput("pend_we", 32'(weA), 1);
    rstN = 1'b0;
    #1;
    checkOutput("arst_we", 32'(weA), 0);
    checkOutput("arst_ready", 32'(readyA), 0);
    checkOutput("arst_count", 32'(countA), 0);
    checkOutput("arst_busy", 32'(busyA), 0);
    checkOutput("arst_addr", 32'(addrA), 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    idleCycles(2);
    checkOutput("post_rst_ready", 32'(readyA), 0);
    checkOutput("scoreboard_left", 32'(expQ.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the control/opcode decoder: accepts symbolic instruction fields over a valid/ready stream and emits 16-bit machine words in the WISC encoding.
- Writes each encoded word sequentially into instruction memory.
- Serves as the boot/program loader in front of the imem write port. Enables self-checking benches and runtime program load without external hex files.
- Validates field ranges per opcode and stops on HLT, on an illegal field, or on address-space overflow.

Parameters:
- ADDR_W, 8, imem word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, first imem word address written after start.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load session; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  loader can accept a bundle this cycle.
- in_opcode  input  4  instruction opcode, 0x0–0xF.
- in_rd  input  4  destination register (rt for LW/SW).
- in_rs  input  4  source register 1.
- in_rt  input  4  source register 2.
- in_imm  input  9  immediate, interpretation depends on opcode.
- in_cond  input  3  branch condition code (B/BR).
- imem_we  output  1  imem write strobe.
- imem_addr  output  ADDR_W  imem write address.
- imem_wdata  output  16  encoded instruction word.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE (HLT written).
- err  output  1  high in ERR.
- err_code  output  2  01 = illegal field, 10 = overflow, 00 otherwise.
- count  output  ADDR_W+1  words written in the current session.

Behaviour:
- Reset (async, rst_n low): state IDLE. in_ready, imem_we, busy, done and err are 0. imem_addr = BASE_ADDR, imem_wdata = 0, err_code = 0, count = 0. Any pending write is squashed immediately.
- States: IDLE, LOAD, DONE, ERR.
- start in IDLE/DONE/ERR: next state LOAD; addr = BASE_ADDR, count = 0, err_code = 0.
- start while in LOAD is ignored.
- in_ready = 1 only in LOAD. Accept occurs when in_valid & in_ready. Throughput is one bundle per cycle.
- Encoding is combinational on the inputs, registered at accept. Fields not listed for an opcode are forced to 0.
  - Opcodes 0–3 and 7 (ADD/SUB/XOR/RED/PADDSB): {op, rd, rs, rt}.
  - Opcodes 4–6 (SLL/SRA/ROR): {op, rd, rs, imm[3:0]}. Legal only if imm[8:4] == 0.
  - Opcodes 8–9 (LW/SW): {op, rd, rs, imm[3:0]}. Legal only if imm[8:3] is all equal (signed 4-bit).
  - Opcodes A–B (LLB/LHB): {op, rd, imm[7:0]}. Legal only if imm[8] == 0.
  - Opcode C (B): {op, cond, imm[8:0]}.
  - Opcode D (BR): {op, cond, 1'b0, rs, 4'h0}.
  - Opcode E (PCS): {op, rd, 8'h00}.
  - Opcode F (HLT): 16'hF000.
- Legal accept at cycle t:
  - At t+1: imem_we = 1, imem_addr = current address, imem_wdata = encoded word.
  - The address register then increments and count increments.
  - imem_we is 0 in every cycle without a preceding accept.
- Illegal field at accept: no write. Next state ERR with err_code = 01; in_ready drops the following cycle.
- HLT accepted: word is written at t+1. Next state DONE; in_ready = 0 from t+1.
- Overflow: a non-HLT word accepted at address 2^ADDR_W−1 is still written. Next state ERR with err_code = 10. Address does not wrap into further writes.
- HLT at the last address goes to DONE, not ERR.
- DONE and ERR hold until start. done, err and err_code are sticky.
- count saturates at 2^ADDR_W.
- in_valid while not in LOAD is ignored; no state change.

Test Plan:
- Reset, start, stream ADD rd=3 rs=1 rt=2 then HLT -> writes 0x0312 @0 and 0xF000 @1 on consecutive cycles; done=1, count=2, in_ready=0.
- Back-to-back LW rd=4 rs=5 imm=0x1FE, LLB rd=2 imm=0x0AB, B cond=3 imm=0x1FF, BR cond=7 rs=6, PCS rd=9 -> writes 0x845E, 0xA2AB, 0xC7FF, 0xDE60, 0xE900 at addresses 0–4, one per cycle, no bubbles.
- SLL imm=0x010 after one valid ADD -> only the ADD is written; err=1, err_code=01, no imem_we for the SLL. Subsequent start clears err and restarts at BASE_ADDR.
- ADDR_W=2, four non-HLT words -> all four written @0..3; err_code=10 after the 4th. A fifth in_valid is not accepted.
- Assert rst_n=0 in the same cycle as an accept -> imem_we stays 0, state IDLE, count=0, in_ready=0 immediately, without waiting for a clock edge.
- in_valid toggling with gaps, plus start pulsed mid-LOAD -> start ignored; only valid&ready cycles produce writes; addresses stay contiguous.
